// File: rtl/ulpi_rx_framer.sv
// ULPI RX framer: splits RX CMD from packet bytes, packs words into an FWFT FIFO, reports len/CRC/error per packet.
// Latency: word pushed one edge after its last byte; no backpressure to the PHY, a push into a full FIFO is dropped and flagged.
module ulpi_rx_framer #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CRC_EN     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     ulpi_data_in,
  input  logic                           ulpi_dir,
  input  logic                           ulpi_nxt,
  output logic [7:0]                     rx_cmd,
  output logic                           rx_cmd_valid,
  output logic [8*WORD_BYTES-1:0]        word_data,
  output logic [$clog2(WORD_BYTES+1)-1:0] word_bytes,
  output logic                           word_last,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic                           pkt_done,
  output logic [15:0]                    pkt_len,
  output logic                           pkt_crc_ok,
  output logic                           pkt_err,
  output logic                           overflow,
  output logic                           rx_active
);
  localparam int BW = $clog2(WORD_BYTES+1);
  localparam int DW = 8*WORD_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, TURN, BUS, PKT} state_t;
  typedef struct packed {
    logic          last;
    logic [BW-1:0] bytes;
    logic [DW-1:0] data;
  } ent_t;

  state_t        state;
  logic [DW-1:0] asm_dat;
  logic [BW-1:0] asm_cnt;
  logic [15:0]   len, crc;
  logic          err;

  // Snapshot of a finished packet, flushed on the following edge so a new PID can reuse the assembly register.
  logic          pend;
  logic [DW-1:0] pend_dat;
  logic [BW-1:0] pend_cnt;
  logic [15:0]   pend_len;
  logic          pend_ok, pend_err;

  ent_t          mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, pop, push_req, push_ok, drop, data_byte, full_word, crc_ok_now;
  ent_t          push_ent, head;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign full_word  = (asm_cnt == BW'(WORD_BYTES));
  assign data_byte  = (state == PKT) && ulpi_dir && ulpi_nxt;
  assign crc_ok_now = (CRC_EN == 0) || (len == 16'd1) || ((len >= 16'd3) && (crc == 16'hB001));

  always_comb begin
    push_req       = 1'b0;
    push_ent.data  = asm_dat;
    push_ent.bytes = asm_cnt;
    push_ent.last  = 1'b0;
    if (pend) begin
      push_req       = (pend_cnt != '0);
      push_ent.data  = pend_dat;
      push_ent.bytes = pend_cnt;
      push_ent.last  = 1'b1;
    end else begin
      push_req = data_byte && full_word;
    end
  end

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign word_valid = (count != '0);
  assign pop        = word_valid && word_ready;
  assign push_ok    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign head       = mem[rd_ptr];
  assign word_data  = head.data;
  assign word_bytes = head.bytes;
  assign word_last  = head.last;
  assign rx_active  = (state == PKT);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rx_cmd       <= 8'h00;
      rx_cmd_valid <= 1'b0;
      asm_dat      <= '0;
      asm_cnt      <= '0;
      len          <= 16'd0;
      crc          <= 16'hFFFF;
      err          <= 1'b0;
      pend         <= 1'b0;
      pend_dat     <= '0;
      pend_cnt     <= '0;
      pend_len     <= 16'd0;
      pend_ok      <= 1'b0;
      pend_err     <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_len      <= 16'd0;
      pkt_crc_ok   <= 1'b0;
      pkt_err      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      rx_cmd_valid <= 1'b0;
      pkt_done     <= 1'b0;
      pend         <= 1'b0;
      if (drop) overflow <= 1'b1;
      if (drop && !pend) err <= 1'b1;
      if (pend) begin
        pkt_done   <= 1'b1;
        pkt_len    <= pend_len;
        pkt_crc_ok <= pend_ok;
        pkt_err    <= pend_err | drop;
      end
      case (state)
        IDLE: if (ulpi_dir) state <= TURN;
        TURN: state <= ulpi_dir ? BUS : IDLE;
        BUS: begin
          if (!ulpi_dir) begin
            state <= IDLE;
          end else if (!ulpi_nxt) begin
            rx_cmd       <= ulpi_data_in;
            rx_cmd_valid <= 1'b1;
          end else begin
            asm_dat <= DW'(ulpi_data_in);
            asm_cnt <= BW'(1);
            len     <= 16'd1;
            crc     <= 16'hFFFF;
            err     <= 1'b0;
            state   <= PKT;
          end
        end
        PKT: begin
          if (ulpi_dir && ulpi_nxt) begin
            if (full_word) begin
              asm_dat <= DW'(ulpi_data_in);
              asm_cnt <= BW'(1);
            end else begin
              for (int i = 0; i < WORD_BYTES; i++)
                if (asm_cnt == BW'(i)) asm_dat[8*i +: 8] <= ulpi_data_in;
              asm_cnt <= asm_cnt + BW'(1);
            end
            len <= (len == 16'hFFFF) ? len : len + 16'd1;
            crc <= crc16_upd(crc, ulpi_data_in);
          end else begin
            if (ulpi_dir) begin
              rx_cmd       <= ulpi_data_in;
              rx_cmd_valid <= 1'b1;
            end
            if (!ulpi_dir || (ulpi_data_in[5:4] != 2'b01)) begin
              pend     <= 1'b1;
              pend_dat <= asm_dat;
              pend_cnt <= asm_cnt;
              pend_len <= len;
              pend_ok  <= crc_ok_now;
              pend_err <= err;
              asm_dat  <= '0;
              asm_cnt  <= '0;
              state    <= ulpi_dir ? BUS : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ulpi_rx_framer.sv
// Directed bench for ulpi_rx_framer (WORD_BYTES=4, FIFO_DEPTH=4): words and packet reports are collected by monitors and checked in order.
module tb_ulpi_rx_framer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ulpi_data_in;
  logic        ulpi_dir, ulpi_nxt;
  logic [7:0]  rx_cmd;
  logic        rx_cmd_valid;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_last, word_valid, word_ready;
  logic        pkt_done;
  logic [15:0] pkt_len;
  logic        pkt_crc_ok, pkt_err, overflow, rx_active;

  ulpi_rx_framer #(.WORD_BYTES(4), .FIFO_DEPTH(4), .CRC_EN(1)) dut (
    .clk(clk), .rst(rst), .ulpi_data_in(ulpi_data_in), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
    .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid), .word_data(word_data), .word_bytes(word_bytes),
    .word_last(word_last), .word_valid(word_valid), .word_ready(word_ready), .pkt_done(pkt_done),
    .pkt_len(pkt_len), .pkt_crc_ok(pkt_crc_ok), .pkt_err(pkt_err), .overflow(overflow), .rx_active(rx_active)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; logic [2:0] b; logic l;} wrd_t;
  typedef struct {logic [15:0] len; logic ok; logic err;} pkt_t;
  wrd_t wq[$];
  pkt_t pq[$];
  int   rxv_cnt = 0;
  int   n_cmp = 0, n_err = 0;

  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) wq.push_back('{word_data, word_bytes, word_last});
    if (!rst && pkt_done) pq.push_back('{pkt_len, pkt_crc_ok, pkt_err});
    if (!rst && rx_cmd_valid) rxv_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic d, input logic n, input logic [7:0] x);
    ulpi_dir = d; ulpi_nxt = n; ulpi_data_in = x;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 8'h00);
  endtask

  // Both turnaround-side cycles carry junk with nxt=1, then RX CMD 0x10 (RxActive set).
  task automatic start_pkt();
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b0, 8'h10);
  endtask

  task automatic dbyte(input logic [7:0] x);
    step(1'b1, 1'b1, x);
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [2:0] b, input logic l);
    wrd_t w;
    chk({tag, " avail"}, 64'(wq.size() > 0), 64'd1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      chk({tag, " data"}, 64'(w.d), 64'(d));
      chk({tag, " bytes"}, 64'(w.b), 64'(b));
      chk({tag, " last"}, 64'(w.l), 64'(l));
    end
  endtask

  task automatic get_pkt(input string tag, output pkt_t p);
    chk({tag, " avail"}, 64'(pq.size() > 0), 64'd1);
    if (pq.size() > 0) p = pq.pop_front();
    else p = '{len: 16'hxxxx, ok: 1'bx, err: 1'bx};
  endtask

  initial begin
    logic [7:0] pat [4];
    pkt_t p;
    int   base;
    pat = '{8'h12, 8'h34, 8'h56, 8'h78};
    rst = 1'b1; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00; word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst word_valid", 64'(word_valid), 64'd0);
    chk("rst pkt_done", 64'(pkt_done), 64'd0);
    chk("rst rx_cmd", 64'(rx_cmd), 64'h00);
    chk("rst rx_cmd_valid", 64'(rx_cmd_valid), 64'd0);
    chk("rst pkt_len", 64'(pkt_len), 64'd0);
    chk("rst crc/err/ovf/act", 64'({pkt_crc_ok, pkt_err, overflow, rx_active}), 64'd0);
    rst = 1'b0;
    idle(2);

    // Single 66-byte packet
    base = rxv_cnt;
    start_pkt();
    for (int i = 0; i < 64; i++) begin
      dbyte(pat[i % 4]);
      if (i == 10) chk("t1 rx_active mid", 64'(rx_active), 64'd1);
    end
    dbyte(8'hFF);
    dbyte(8'h87);
    step(1'b0, 1'b0, 8'h00);
    chk("t1 rx_active end", 64'(rx_active), 64'd0);
    idle(4);
    for (int i = 0; i < 16; i++) chk_word("t1 word", 32'h78563412, 3'd4, 1'b0);
    chk_word("t1 tail", 32'h000087FF, 3'd2, 1'b1);
    chk("t1 no extra words", 64'(wq.size()), 64'd0);
    get_pkt("t1 pkt", p);
    chk("t1 pkt_len", 64'(p.len), 64'd66);
    chk("t1 pkt_err", 64'(p.err), 64'd0);
    chk("t1 one pkt_done", 64'(pq.size()), 64'd0);
    chk("t1 rx_cmd pulses", 64'(rxv_cnt - base), 64'd1);
    chk("t1 rx_cmd", 64'(rx_cmd), 64'h10);

    // Handshake, good zero-length DATA0, bad zero-length DATA0
    start_pkt(); dbyte(8'hD2); step(1'b0, 1'b0, 8'h00); idle(4);
    get_pkt("t2a pkt", p);
    chk("t2a len", 64'(p.len), 64'd1);
    chk("t2a crc_ok", 64'(p.ok), 64'd1);
    chk_word("t2a word", 32'h000000D2, 3'd1, 1'b1);
    start_pkt(); dbyte(8'hC3); dbyte(8'h00); dbyte(8'h00); step(1'b0, 1'b0, 8'h00); idle(4);
    get_pkt("t2b pkt", p);
    chk("t2b len", 64'(p.len), 64'd3);
    chk("t2b crc_ok", 64'(p.ok), 64'd1);
    chk_word("t2b word", 32'h000000C3, 3'd3, 1'b1);
    start_pkt(); dbyte(8'hC3); dbyte(8'h00); dbyte(8'h01); step(1'b0, 1'b0, 8'h00); idle(4);
    get_pkt("t2c pkt", p);
    chk("t2c crc_ok", 64'(p.ok), 64'd0);
    chk_word("t2c word", 32'h000100C3, 3'd3, 1'b1);

    // Exact multiple of the word size, with an RxActive-high RX CMD mid-packet
    start_pkt();
    for (int i = 1; i <= 4; i++) dbyte(8'(i));
    step(1'b1, 1'b0, 8'h10);
    for (int i = 5; i <= 8; i++) dbyte(8'(i));
    step(1'b0, 1'b0, 8'h00); idle(4);
    chk_word("t3 w0", 32'h04030201, 3'd4, 1'b0);
    chk_word("t3 w1", 32'h08070605, 3'd4, 1'b1);
    get_pkt("t3 pkt", p);
    chk("t3 len", 64'(p.len), 64'd8);
    chk("t3 single pkt", 64'(pq.size()), 64'd0);

    // Overflow: six words into a four-deep FIFO with no consumer
    word_ready = 1'b0;
    start_pkt();
    for (int i = 1; i <= 24; i++) dbyte(8'(i));
    step(1'b0, 1'b0, 8'h00); idle(4);
    chk("t4 overflow", 64'(overflow), 64'd1);
    chk("t4 word_valid", 64'(word_valid), 64'd1);
    get_pkt("t4 pkt", p);
    chk("t4 len", 64'(p.len), 64'd24);
    chk("t4 pkt_err", 64'(p.err), 64'd1);
    word_ready = 1'b1;
    idle(8);
    chk_word("t4 w0", 32'h04030201, 3'd4, 1'b0);
    chk_word("t4 w1", 32'h08070605, 3'd4, 1'b0);
    chk_word("t4 w2", 32'h0C0B0A09, 3'd4, 1'b0);
    chk_word("t4 w3", 32'h100F0E0D, 3'd4, 1'b0);
    chk("t4 kept 4", 64'(wq.size()), 64'd0);
    start_pkt(); dbyte(8'hD2); step(1'b0, 1'b0, 8'h00); idle(4);
    get_pkt("t4 good pkt", p);
    chk("t4 good pkt_err", 64'(p.err), 64'd0);
    chk("t4 overflow sticky", 64'(overflow), 64'd1);
    chk_word("t4 good word", 32'h000000D2, 3'd1, 1'b1);

    // RxActive drop then back-to-back PID
    base = rxv_cnt;
    start_pkt();
    dbyte(8'hC3); dbyte(8'h00); dbyte(8'h00);
    step(1'b1, 1'b0, 8'h00);
    dbyte(8'h4B); dbyte(8'h00); dbyte(8'h00);
    step(1'b0, 1'b0, 8'h00); idle(4);
    get_pkt("t5 pkt1", p);
    chk("t5 pkt1 len", 64'(p.len), 64'd3);
    chk("t5 pkt1 ok", 64'(p.ok), 64'd1);
    get_pkt("t5 pkt2", p);
    chk("t5 pkt2 len", 64'(p.len), 64'd3);
    chk("t5 pkt2 ok", 64'(p.ok), 64'd1);
    chk_word("t5 w1", 32'h000000C3, 3'd3, 1'b1);
    chk_word("t5 w2", 32'h0000004B, 3'd3, 1'b1);
    chk("t5 rx_cmd pulses", 64'(rxv_cnt - base), 64'd2);
    chk("t5 rx_cmd", 64'(rx_cmd), 64'h00);

    // Reset mid-packet
    word_ready = 1'b0;
    start_pkt();
    for (int i = 1; i <= 5; i++) dbyte(8'(i));
    chk("t6 word_valid pre", 64'(word_valid), 64'd1);
    rst = 1'b1;
    step(1'b1, 1'b1, 8'h06);
    rst = 1'b0;
    chk("t6 word_valid", 64'(word_valid), 64'd0);
    chk("t6 rx_active", 64'(rx_active), 64'd0);
    chk("t6 overflow cleared", 64'(overflow), 64'd0);
    idle(4);
    chk("t6 no pkt_done", 64'(pq.size()), 64'd0);
    word_ready = 1'b1;
    start_pkt(); dbyte(8'hD2); step(1'b0, 1'b0, 8'h00); idle(4);
    get_pkt("t6 next pkt", p);
    chk("t6 next len", 64'(p.len), 64'd1);
    chk("t6 next ok/err", 64'({p.ok, p.err}), 64'b10);
    chk_word("t6 next word", 32'h000000D2, 3'd1, 1'b1);
    chk("t6 no extra words", 64'(wq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ulpi_rx_framer.md
# ulpi_rx_framer

Parametrised ULPI receive framer in the ULPI clock domain, between the PHY pins and the packet/decode logic of `top`. It tracks bus ownership (`dir`) and turnaround, separates RX CMD bytes from packet data bytes, and packs data bytes little-endian into `WORD_BYTES`-wide words. Words go into a first-word-fall-through FIFO of `FIFO_DEPTH` entries. Per packet it reports byte length, USB CRC16 status and overflow error.

## Interface
- `WORD_BYTES`, 4: bytes per output word, 1..8.
- `FIFO_DEPTH`, 16: word FIFO entries, power of two, ≥2.
- `CRC_EN`, 1: 1 = check CRC16; 0 = `pkt_crc_ok` forced 1.

- `clk`  in  1: ULPI clock (60 MHz); all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ulpi_data_in`  in  8: ULPI data bus.
- `ulpi_dir`  in  1: PHY owns bus when 1.
- `ulpi_nxt`  in  1: data-byte qualifier.
- `rx_cmd`  out  8: last RX CMD byte; reset 0x00.
- `rx_cmd_valid`  out  1: 1-cycle pulse on each RX CMD; reset 0.
- `word_data`  out  8·WORD_BYTES: FIFO head; byte 0 = first received, in [7:0]; unused upper bytes 0.
- `word_bytes`  out  $clog2(WORD_BYTES+1): valid bytes in head word.
- `word_last`  out  1: head word ends a packet.
- `word_valid`  out  1: FIFO not empty; reset 0.
- `word_ready`  in  1: consumer pop; pop = valid & ready.
- `pkt_done`  out  1: 1-cycle pulse at packet end; reset 0.
- `pkt_len`  out  16: bytes in finished packet, PID and CRC included; held until next `pkt_done`; reset 0. Saturates at 0xFFFF.
- `pkt_crc_ok`  out  1: valid with `pkt_done`; reset 0.
- `pkt_err`  out  1: valid with `pkt_done`; 1 if any word of the packet was dropped; reset 0.
- `overflow`  out  1: sticky; cleared only by `rst`; reset 0.
- `rx_active`  out  1: high in PKT state; reset 0.

## Operation
- Inputs are sampled directly at each rising edge. There is no input register.
- FSM states: IDLE, TURN, BUS, PKT.
- IDLE: `dir`=0.
  - `dir`=1 → TURN.
- TURN: a single turnaround cycle. Data and `nxt` are ignored.
  - Next cycle: `dir`=1 → BUS; `dir`=0 → IDLE.
- BUS:
  - `dir`=0 → IDLE.
  - `nxt`=0: RX CMD captured; `rx_cmd_valid` pulses.
  - `nxt`=1: first data byte (PID). It starts a packet and the FSM goes to PKT.
- PKT:
  - `nxt`=1: data byte; appended, `pkt_len`+1, CRC updated.
  - `nxt`=0: RX CMD captured and pulsed.
    - If bits[5:4] ≠ 2'b01 (RxActive dropped), the packet ends and the FSM goes to BUS.
  - `dir`=0: the packet ends and the FSM goes to IDLE. Data on that cycle is ignored.
- Word packing:
  - A completed word stays in the assembly register until the next data byte arrives or the packet ends.
  - It is then pushed with `word_last` = end-of-packet.
  - At end with a partial word, that word is pushed with `last`=1 and `word_bytes` = its byte count.
- CRC16:
  - Reflected, poly 0xA001, init 0xFFFF, LSB first.
  - Covers every data byte after the PID, CRC bytes included.
  - `pkt_crc_ok`:
    - 1 if len==1 (handshake).
    - 1 if len≥3 and residual==0xB001.
    - Otherwise 0.
- FIFO:
  - FWFT, `FIFO_DEPTH` entries of {data, bytes, last}.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: word dropped, `overflow`←1, packet `pkt_err`←1.
- `rst` mid-packet:
  - FIFO emptied, assembly and CRC cleared, FSM → IDLE.
  - No `pkt_done` is generated.

## Timing
- Word latency:
  - The last byte of a word is sampled at edge t.
  - The push happens at edge t+1, on the next byte or on end detection.
  - `word_valid` is high after edge t+1.
- End detected at edge t:
  - Final push, `pkt_done`, `pkt_len` and `pkt_crc_ok` all register at edge t+1.
  - `rx_active` falls after edge t.
- `rx_cmd`/`rx_cmd_valid` register at the edge after the RX CMD byte is sampled.
- Packet back-to-back with a new PID in the cycle immediately after RxActive drops (BUS→PKT): supported with no lost bytes.
- Pop and push in the same cycle, empty FIFO:
  - The pushed word appears the following cycle.
  - No bypass.

## Test plan
- **Single packet:**
  - Stimulus: `dir`↑; then RX CMD 0x10; then `nxt`=1 with 64 bytes cycling 0x12,0x34,0x56,0x78; then 0xFF, 0x87; then `dir`=0. `WORD_BYTES`=4, `word_ready`=1.
  - Required: 16 words of 0x78563412 with last=0; then final word 0x87FF, bytes=2, last=1; `pkt_len`=66; `pkt_done` one cycle; `rx_cmd`=0x10 pulse once.
- **Handshake and zero-length DATA0:**
  - Stimulus: PID 0xD2 alone → `pkt_len`=1, crc_ok=1.
  - Stimulus: bytes C3,00,00 → `pkt_len`=3, crc_ok=1.
  - Stimulus: C3,00,01 → crc_ok=0.
- **Exact multiple:**
  - Stimulus: 8 bytes 0x01..0x08, `WORD_BYTES`=4.
  - Required: words 0x04030201 (last=0) and 0x08070605 (last=1, bytes=4).
- **Overflow:**
  - Stimulus: `word_ready`=0, `FIFO_DEPTH`=4, 24-byte packet.
  - Required: 4 words kept, `overflow`=1 sticky, `pkt_err`=1. A later good packet reports `pkt_err`=0 while `overflow` stays 1.
- **RxActive end:**
  - Stimulus: mid-packet RX CMD 0x00 with `dir` held high, then PID 0x4B next cycle.
  - Required: first `pkt_done`, then second packet framed correctly; turnaround cycle data 0xAA with `nxt`=1 ignored.
- **Reset mid-packet:**
  - Stimulus: `rst` for 1 cycle after 5 data bytes.
  - Required: `word_valid`=0, no `pkt_done`, FSM IDLE. Next packet normal.
